seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the BCD digit values and error flags produced by the cascaded decade down-counter stages and scans them onto shared segment lines. It adds leading-zero blanking, an error glyph, an out-of-range glyph, and whole-display blinking for the "count reached zero" indication.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ DEAD_CYCLES+2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_FRAMES, 125: full scan frames per blink half-period.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- digits  in  16  BCD digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- err  in  4  per-digit error flag from the counter stage; bit i maps to digit i.
- dp_en  in  4  decimal point enable per digit, active-high.
- blank_lz  in  1  leading-zero blanking enable.
- blink  in  1  blink the whole display while high.
- an  out  4  anode enables, active-low; bit i drives digit i.
- seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse when the digit 3 slot ends.

## Operation
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. When it wraps, the scan index (2 bits) advances 0→1→2→3→0.
- At slot start (prescaler==0), the selected digit's code, err bit, dp_en bit and blank decision are sampled and registered. Input changes during a slot are ignored until the next slot.
- Glyph priority, highest first:
  - err[i]=1 → "E".
  - code>9 → "-".
  - blanked → all segments off.
  - otherwise decimal 0–9.
- Leading-zero blanking applies only when blank_lz=1:
  - digit 3 is blanked if its code is 0.
  - digit 2 is blanked if digits 3 and 2 are 0.
  - digit 1 is blanked if digits 3, 2 and 1 are 0.
  - digit 0 is never blanked.
  - A digit with err set is never blanked. Blanking uses the raw codes, so an err on a higher digit does not stop a lower zero digit from being blanked.
- Patterns (hex of {g..a}, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - E=06, "-"=3F, blank=7F
- dp is low when dp_en[i]=1 and the digit is not blanked.
- Blink: a frame counter counts frame_done pulses 0..BLINK_FRAMES-1 and toggles the phase bit on wrap.
  - When blink=1 and phase=0, an=1111.
  - When blink=0, the frame counter is held at 0 and phase at 1, so asserting blink starts a full visible half-period.

## Timing
- All outputs are registered.
- Reset values: an=1111, seg=7F, dp=1, frame_done=0, prescaler=0, scan index=0, frame counter=0, phase=1.
- Slot i, relative to slot start cycle t:
  - seg/dp are valid from t+1.
  - an[i]=0 from t+1+DEAD_CYCLES through the end of the slot.
  - All other anodes stay 1.
- Latency from a digits change to its display is at most 4·REFRESH_DIV+1 cycles.
- frame_done is high for exactly the cycle in which prescaler==REFRESH_DIV-1 and scan index==3.
- Reset asserted mid-slot: the next cycle shows the reset values, and scanning restarts at digit 0 after reset deasserts.
- Exactly one anode is low at any time, or none.

## Structure
- Package seg7_pkg holds the pattern constants SEG_0..SEG_9, SEG_E, SEG_DASH and SEG_BLANK.
- Sub-module bcd_to_seg7, combinational: inputs code[3:0], err, blank; output seg[6:0] using the priority above.
- Top level holds the prescaler, scan index, blank logic, dead-time, blink counter and output registers.

## Test plan
- Reset: hold reset 3 cycles → an=1111, seg=7F, dp=1, frame_done=0. Release → first an=1110 occurs DEAD_CYCLES+1 cycles later.
- Scan, with REFRESH_DIV=6, DEAD_CYCLES=2 and digits=16'h1234, blank_lz=0:
  - seg sequence is 19, 30, 24, 79 for an 1110, 1101, 1011, 0111.
  - Each an is low for 3 cycles per slot.
  - frame_done pulses once every 24 cycles.
- Leading zeros: digits=16'h0050, blank_lz=1 → digit 3 and digit 2 show 7F, digit 1 shows 12, digit 0 shows 40. With digits=16'h0000, digit 0 shows 40 and the rest show 7F.
- Error and range: digits=16'h0A00, err=4'b0001, blank_lz=1:
  - digit 0 shows 06.
  - digit 2 shows 3F.
  - digit 3 is blanked (7F).
  - digit 1 shows 40.
  - With dp_en=4'b0100, dp is low only in the digit 2 slot.
- Blink: BLINK_FRAMES=2, blink=1 → anodes visible for 2 frames, then 1111 for 2 frames, repeating. Dropping blink → visible on the next slot.
- Reset mid-operation: assert reset during the digit 2 slot's active window → an=1111 on the next cycle. After release, scanning resumes at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment patterns for a common-anode display, active-low, bit order {g,f,e,d,c,b,a}.
// Shared by the glyph decoder and the scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low one-hot anode pattern for a scan index.
  function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational glyph decoder: error "E" over out-of-range "-" over blank over 0-9.
// Zero latency; purely combinational.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       err,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (err) begin
      seg = SEG_E;
    end else if (code > 4'd9) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (code)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scanner with leading-zero blanking, dead time and blink.
// Digit inputs are sampled once per slot; seg/dp follow one cycle after slot start.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  err,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PSC_W = $clog2(REFRESH_DIV + 1);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PSC_W-1:0] PSC_LAST     = PSC_W'(REFRESH_DIV - 1);
  localparam logic [PSC_W-1:0] PSC_PRE_LAST = PSC_W'(REFRESH_DIV - 2);
  localparam logic [PSC_W-1:0] PSC_DEAD     = PSC_W'(DEAD_CYCLES);
  localparam logic [FRM_W-1:0] FRM_LAST     = FRM_W'(BLINK_FRAMES - 1);

  logic [PSC_W-1:0] psc_q;
  logic [1:0]       idx_q;
  logic [FRM_W-1:0] frm_q;
  logic             phase_q;
  logic             vis_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             fd_q;

  logic [3:0] code;
  logic       lz;
  logic       blank;
  logic [6:0] seg_d;
  logic       dp_d;
  logic       vis_d;
  logic       an_on;
  logic [3:0] an_d;

  // Blanking looks at raw codes only; err only protects the digit that carries it.
  always_comb begin
    code = digits[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    lz = (digits[15:12] == 4'd0);
      2'd2:    lz = (digits[15:8] == 8'd0);
      2'd1:    lz = (digits[15:4] == 12'd0);
      default: lz = 1'b0;
    endcase
    blank = blank_lz && lz && !err[idx_q];
    dp_d  = ~(dp_en[idx_q] & ~blank);
  end

  bcd_to_seg7 u_dec (
    .code  (code),
    .err   (err[idx_q]),
    .blank (blank),
    .seg   (seg_d)
  );

  // Visibility is frozen at slot start so a blink edge never truncates a slot.
  always_comb begin
    vis_d = (psc_q == '0) ? !(blink && !phase_q) : vis_q;
    an_on = vis_d && (psc_q >= PSC_DEAD) && (psc_q != PSC_LAST);
    an_d  = an_on ? anode_sel_n(idx_q) : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q   <= '0;
      idx_q   <= 2'd0;
      frm_q   <= '0;
      phase_q <= 1'b1;
      vis_q   <= 1'b1;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      psc_q <= (psc_q == PSC_LAST) ? '0 : psc_q + 1'b1;
      if (psc_q == PSC_LAST) begin
        idx_q <= idx_q + 2'd1;
      end
      if (psc_q == '0) begin
        seg_q <= seg_d;
        dp_q  <= dp_d;
        vis_q <= vis_d;
      end
      an_q <= an_d;
      fd_q <= (psc_q == PSC_PRE_LAST) && (idx_q == 2'd3);
      if (!blink) begin
        frm_q   <= '0;
        phase_q <= 1'b1;
      end else if (fd_q) begin
        if (frm_q == FRM_LAST) begin
          frm_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          frm_q <= frm_q + 1'b1;
        end
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a slot-level reference model queues the expected
// anode window of every visible slot; a monitor pops and compares as windows appear.
module tb_seg7_scan_driver;

  localparam int RD    = 6;
  localparam int DEAD  = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  err = 4'h0;
  logic [3:0]  dp_en = 4'h0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg7_scan_driver #(
    .REFRESH_DIV  (RD),
    .DEAD_CYCLES  (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .err        (err),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic r_q = 1'b0;
  logic started = 1'b0;
  exp_t q[$];
  logic [6:0] tbl [0:9];

  // cyc counts cycles since the last reset edge, i.e. the position within the scan.
  always @(posedge clk) begin
    cyc <= reset ? 0 : cyc + 1;
    r_q <= reset;
    if (reset) started <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one decision per slot from the display rules, plus blink phase.
  initial begin : model
    int   frames;
    logic phase;
    frames = 0;
    phase  = 1'b1;
    forever begin
      @(negedge clk);
      if (r_q) begin
        q.delete();
        frames = 0;
        phase  = 1'b1;
      end
      if (started && !reset) begin
        if (cyc % RD == 0) begin
          int         i;
          logic [3:0] d [4];
          logic       blanked;
          exp_t       e;
          i = (cyc / RD) % 4;
          for (int k = 0; k < 4; k++) d[k] = digits[4*k +: 4];
          blanked = blank_lz && !err[i] && (i != 0);
          for (int k = i; k < 4; k++) if (d[k] != 4'd0) blanked = 1'b0;
          if (err[i])          e.seg = 7'h06;
          else if (d[i] > 9)   e.seg = 7'h3F;
          else if (blanked)    e.seg = 7'h7F;
          else                 e.seg = tbl[d[i]];
          e.dp  = !(dp_en[i] && !blanked);
          e.an  = 4'hF ^ (4'b0001 << i);
          e.cyc = 32'(cyc + 1 + DEAD);
          if (!blink || phase) q.push_back(e);
        end
        if (!blink) begin
          frames = 0;
          phase  = 1'b1;
        end else if (cyc % FRAME == FRAME - 1) begin
          frames++;
          if (frames == BF) begin
            frames = 0;
            phase  = !phase;
          end
        end
      end
    end
  end

  // Monitor: every anode window must match the next queued slot exactly.
  initial begin : monitor
    logic       run_active;
    int         run_len;
    logic [3:0] run_an;
    exp_t       e;
    run_active = 1'b0;
    run_len    = 0;
    run_an     = 4'hF;
    forever begin
      @(negedge clk);
      if (r_q) begin
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);
        run_active = 1'b0;
      end else if (started) begin
        if (frame_done || (cyc % FRAME == FRAME - 1))
          check("frame_done", frame_done, (cyc % FRAME == FRAME - 1));
        if (an !== 4'hF) begin
          if (!run_active) begin
            run_active = 1'b1;
            run_len    = 1;
            if (q.size() == 0) begin
              check("unexpected_anode", an, 4'hF);
              run_an = 4'hF;
            end else begin
              e      = q.pop_front();
              run_an = e.an;
              check("slot_an", an, e.an);
              check("slot_seg", seg, e.seg);
              check("slot_dp", dp, e.dp);
              check("slot_start_cyc", cyc, e.cyc);
            end
          end else begin
            run_len++;
            check("an_hold", an, run_an);
          end
        end else if (run_active) begin
          run_active = 1'b0;
          check("an_window_len", run_len, RD - 1 - DEAD);
        end
      end
    end
  end

  task automatic reset_in_digit2_window();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 2 * RD + DEAD + 2; i++) tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin : stimulus
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30; tbl[4] = 7'h19;
    tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78; tbl[8] = 7'h00; tbl[9] = 7'h10;

    digits = 16'h1234;
    reset  = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2 * FRAME);

    digits   = 16'h0050;
    blank_lz = 1'b1;
    tick(2 * FRAME);
    digits = 16'h0000;
    tick(2 * FRAME);

    digits = 16'h0A00;
    err    = 4'b0001;
    dp_en  = 4'b0100;
    tick(2 * FRAME);

    digits = 16'h1234;
    err    = 4'b0000;
    dp_en  = 4'b1010;
    blink  = 1'b1;
    tick(9 * FRAME + 5);
    blink = 1'b0;
    tick(2 * FRAME);

    reset_in_digit2_window();
    tick(2 * FRAME);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom % 6 == 0) begin
        for (int k = 0; k < 4; k++)
          digits[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
        err      = ($urandom % 4 == 0) ? 4'(1 << ($urandom % 4)) : 4'h0;
        dp_en    = 4'($urandom % 16);
        blank_lz = 1'($urandom % 2);
      end
      if ($urandom % 150 == 0) blink = !blink;
      if (i == 1000) reset_in_digit2_window();
      tick(1);
    end
    blink = 1'b0;
    tick(FRAME);

    check("queue_drained", (q.size() <= 1), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
